// File: rtl/jpeg_rle_encoder_pkg.sv
// Shared JPEG entropy-path definitions: coefficient/block geometry, symbol
// flag bit positions (shared with the VLC stage) and the RLE FSM states.
package jpeg_rle_encoder_pkg;

  localparam int unsigned JPEG_COEF_W    = 11;
  localparam int unsigned JPEG_BLOCK_LEN = 64;
  localparam int unsigned JPEG_RUN_W     = 4;
  localparam int unsigned JPEG_ZRL_RUN   = (1 << JPEG_RUN_W) - 1;

  // Symbol flag vector layout
  localparam int unsigned SYM_FLAG_W = 4;
  localparam int unsigned SYM_DC     = 0;
  localparam int unsigned SYM_EOB    = 1;
  localparam int unsigned SYM_ZRL    = 2;
  localparam int unsigned SYM_LAST   = 3;

  typedef enum logic {
    S_RUN = 1'b0,
    S_ZRL = 1'b1
  } rle_state_e;

endpackage

// File: rtl/jpeg_sym_reg.sv
// One-entry output holding register for RLE symbols with valid/ready.
// Fields stay stable while out_valid is high and out_ready is low.
module jpeg_sym_reg
  import jpeg_rle_encoder_pkg::*;
#(
  parameter int unsigned RUN_W  = JPEG_RUN_W,
  parameter int unsigned COEF_W = JPEG_COEF_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  out_ready,
  input  logic [RUN_W-1:0]      run_in,
  input  logic [COEF_W-1:0]     value_in,
  input  logic [SYM_FLAG_W-1:0] flags_in,
  output logic                  out_valid,
  output logic [RUN_W-1:0]      out_run,
  output logic [COEF_W-1:0]     out_value,
  output logic [SYM_FLAG_W-1:0] out_flags
);

  logic                  valid_q, valid_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [COEF_W-1:0]     value_q, value_d;
  logic [SYM_FLAG_W-1:0] flags_q, flags_d;

  // Load a new symbol, or drop valid once the current one is taken.
  always_comb begin
    valid_d = valid_q;
    run_d   = run_q;
    value_d = value_q;
    flags_d = flags_q;
    if (load) begin
      valid_d = 1'b1;
      run_d   = run_in;
      value_d = value_in;
      flags_d = flags_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      run_q   <= '0;
      value_q <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      run_q   <= run_d;
      value_q <= value_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign out_run   = run_q;
  assign out_value = value_q;
  assign out_flags = flags_q;

endmodule

// File: rtl/jpeg_rle_encoder.sv
// Zero-run-length encoder for one zig-zag ordered 8x8 block: emits DC,
// (run, value) AC symbols, ZRL for runs longer than 15 and a trailing EOB.
module jpeg_rle_encoder
  import jpeg_rle_encoder_pkg::*;
#(
  parameter int unsigned COEF_W    = JPEG_COEF_W,
  parameter int unsigned BLOCK_LEN = JPEG_BLOCK_LEN,
  parameter int unsigned RUN_W     = JPEG_RUN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [COEF_W-1:0] out_value,
  output logic              out_dc,
  output logic              out_eob,
  output logic              out_zrl,
  output logic              out_last
);

  localparam int unsigned      CNT_W    = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] ZRL_CNT  = CNT_W'((1 << RUN_W) - 1);
  localparam logic [CNT_W-1:0] ZRL_SPAN = CNT_W'(1 << RUN_W);
  localparam logic [RUN_W-1:0] ZRL_RUN  = '1;

  rle_state_e           state_q, state_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     zcnt_q, zcnt_d;
  logic [COEF_W-1:0]    hold_val_q, hold_val_d;
  logic                 hold_last_q, hold_last_d;

  logic                  load;
  logic [RUN_W-1:0]      sym_run;
  logic [COEF_W-1:0]     sym_value;
  logic [SYM_FLAG_W-1:0] sym_flags;
  logic [SYM_FLAG_W-1:0] out_flags;
  logic                  in_fire, out_fire;

  // Gated by reset so nothing looks acceptable while the block is held clear.
  assign in_ready = reset && (state_q == S_RUN) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next-state, counters and symbol formation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    zcnt_d      = zcnt_q;
    hold_val_d  = hold_val_q;
    hold_last_d = hold_last_q;
    load        = 1'b0;
    sym_run     = '0;
    sym_value   = '0;
    sym_flags   = '0;
    case (state_q)
      S_RUN: begin
        if (in_fire) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (idx_q == '0) begin
            load               = 1'b1;
            sym_value          = in_coef;
            sym_flags[SYM_DC]  = 1'b1;
            zcnt_d             = '0;
          end else if (in_coef == '0) begin
            if (idx_q == LAST_IDX) begin
              load                = 1'b1;
              sym_flags[SYM_EOB]  = 1'b1;
              sym_flags[SYM_LAST] = 1'b1;
              zcnt_d              = '0;
            end else begin
              zcnt_d = zcnt_q + 1'b1;
            end
          end else if (zcnt_q <= ZRL_CNT) begin
            load                = 1'b1;
            sym_run             = zcnt_q[RUN_W-1:0];
            sym_value           = in_coef;
            sym_flags[SYM_LAST] = (idx_q == LAST_IDX);
            zcnt_d              = '0;
          end else begin
            // Park the coefficient; ZRLs drain the run before it is emitted.
            hold_val_d         = in_coef;
            hold_last_d        = (idx_q == LAST_IDX);
            load               = 1'b1;
            sym_run            = ZRL_RUN;
            sym_flags[SYM_ZRL] = 1'b1;
            zcnt_d             = zcnt_q - ZRL_SPAN;
            state_d            = S_ZRL;
          end
        end
      end
      S_ZRL: begin
        if (out_fire) begin
          load = 1'b1;
          if (zcnt_q > ZRL_CNT) begin
            sym_run            = ZRL_RUN;
            sym_flags[SYM_ZRL] = 1'b1;
            zcnt_d             = zcnt_q - ZRL_SPAN;
          end else begin
            sym_run             = zcnt_q[RUN_W-1:0];
            sym_value           = hold_val_q;
            sym_flags[SYM_LAST] = hold_last_q;
            zcnt_d              = '0;
            state_d             = S_RUN;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Encoder state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RUN;
      idx_q       <= '0;
      zcnt_q      <= '0;
      hold_val_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      zcnt_q      <= zcnt_d;
      hold_val_q  <= hold_val_d;
      hold_last_q <= hold_last_d;
    end
  end

  jpeg_sym_reg #(
    .RUN_W  (RUN_W),
    .COEF_W (COEF_W)
  ) u_sym_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .out_ready (out_ready),
    .run_in    (sym_run),
    .value_in  (sym_value),
    .flags_in  (sym_flags),
    .out_valid (out_valid),
    .out_run   (out_run),
    .out_value (out_value),
    .out_flags (out_flags)
  );

  assign out_dc   = out_flags[SYM_DC];
  assign out_eob  = out_flags[SYM_EOB];
  assign out_zrl  = out_flags[SYM_ZRL];
  assign out_last = out_flags[SYM_LAST];

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Scoreboard bench for jpeg_rle_encoder: the driver queues expected symbols,
// the monitor pops and compares them on every output transfer.
module tb_jpeg_rle_encoder;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [10:0] in_coef;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_run;
  logic signed [10:0] out_value;
  logic               out_dc, out_eob, out_zrl, out_last;

  typedef struct packed {
    logic [3:0]  run;
    logic [10:0] value;
    logic        dc;
    logic        eob;
    logic        zrl;
    logic        last;
  } sym_t;

  sym_t  exp_q[$];
  string dname_q[$];
  int    dgot_q[$];
  int    dwant_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    last_seen = 0;
  bit    rand_en   = 1'b0;
  bit    rdy_fix   = 1'b0;
  int    blk[64];

  jpeg_rle_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_value (out_value),
    .out_dc    (out_dc),
    .out_eob   (out_eob),
    .out_zrl   (out_zrl),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic sym_t mk(int run, int value, bit dc, bit eob, bit zrl, bit last);
    sym_t s;
    s.run   = run[3:0];
    s.value = value[10:0];
    s.dc    = dc;
    s.eob   = eob;
    s.zrl   = zrl;
    s.last  = last;
    return s;
  endfunction

  function automatic string fmt(sym_t s);
    return $sformatf("(run=%0d val=%0d dc=%0b eob=%0b zrl=%0b last=%0b)",
                     s.run, $signed(s.value), s.dc, s.eob, s.zrl, s.last);
  endfunction

  // Direct observations are handed to the monitor, which owns the counters.
  task automatic dcheck(string name, int got, int want);
    dname_q.push_back(name);
    dgot_q.push_back(got);
    dwant_q.push_back(want);
  endtask

  // Independent reference encoder over a whole block held in blk[].
  task automatic model_block();
    int run;
    exp_q.push_back(mk(0, blk[0], 1, 0, 0, 0));
    run = 0;
    for (int i = 1; i < 64; i++) begin
      if (blk[i] == 0) begin
        run++;
      end else begin
        while (run > 15) begin
          exp_q.push_back(mk(15, 0, 0, 0, 1, 0));
          run -= 16;
        end
        exp_q.push_back(mk(run, blk[i], 0, 0, 0, i == 63));
        run = 0;
      end
    end
    if (blk[63] == 0) exp_q.push_back(mk(0, 0, 0, 1, 0, 1));
  endtask

  task automatic send(int c);
    int n;
    bit acc;
    in_valid = 1'b1;
    in_coef  = 11'(c);
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) dcheck("in_timeout", 1, 0);
  endtask

  task automatic send_block();
    for (int i = 0; i < 64; i++) send(blk[i]);
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    dcheck("drain", exp_q.size(), 0);
  endtask

  // out_ready driver: fixed level or 50% random, updated 2 time units after each edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_en ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Monitor: drains direct checks, checks hold stability and scoreboard order.
  initial begin
    sym_t cur, prev, want;
    bit   prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      while (dname_q.size() > 0) begin
        string nm;
        int    g, w;
        nm = dname_q.pop_front();
        g  = dgot_q.pop_front();
        w  = dwant_q.pop_front();
        checks++;
        if (g != w) begin
          failures++;
          $display("FAIL %s got=%0d want=%0d", nm, g, w);
        end
      end
      if (reset !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        cur = {out_run, out_value, out_dc, out_eob, out_zrl, out_last};
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || cur !== prev) begin
            failures++;
            $display("FAIL stable got valid=%0b %s want valid=1 %s",
                     out_valid, fmt(cur), fmt(prev));
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_sym got %s want none", fmt(cur));
          end else begin
            want = exp_q.pop_front();
            if (cur !== want) begin
              failures++;
              $display("FAIL sym got %s want %s", fmt(cur), fmt(want));
            end
          end
          if (cur.last) last_seen++;
        end
        prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
        prev       = cur;
      end
    end
  end

  // Stimulus.
  initial begin
    int cnt, dens, v;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_coef  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    dcheck("rst_out_valid", int'(out_valid), 0);
    dcheck("rst_in_ready", int'(in_ready), 0);
    dcheck("rst_fields", int'({out_run, out_value, out_dc, out_eob, out_zrl, out_last}), 0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    rdy_fix = 1'b1;

    // 1: DC=-5, AC 3,0,0,7, then zeros
    clear_blk();
    blk[0] = -5; blk[1] = 3; blk[4] = 7;
    exp_q.push_back(mk(0, -5, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 3, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 7, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 1));
    send_block();

    // 2: DC=0, 19 zeros, 12, 43 zeros
    clear_blk();
    blk[20] = 12;
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(15, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(3, 12, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 1));
    send_block();

    // 3: DC=1, 62 zeros, AC63=-2: three ZRLs, no EOB, in_ready low 3 cycles
    clear_blk();
    blk[0] = 1; blk[63] = -2;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0));
    repeat (3) exp_q.push_back(mk(15, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(14, -2, 0, 0, 0, 1));
    send_block();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
    end
    dcheck("zrl_in_ready_low", cnt, 3);
    @(posedge clk);
    #1;

    // 6: run of exactly 15 is an ordinary symbol
    clear_blk();
    blk[0] = 2; blk[16] = 4;
    exp_q.push_back(mk(0, 2, 1, 0, 0, 0));
    exp_q.push_back(mk(15, 4, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 1));
    send_block();
    wait_drain();

    // 5: reset while a DC symbol is stalled
    rdy_fix = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send(7);
    @(negedge clk);
    dcheck("stall_valid", int'(out_valid), 1);
    dcheck("stall_value", int'(out_value), 7);
    dcheck("stall_dc", int'(out_dc), 1);
    dcheck("stall_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dcheck("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    rdy_fix = 1'b1;
    clear_blk();
    blk[0] = 9;
    exp_q.push_back(mk(0, 9, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 1));
    send_block();

    // 4: 100 random blocks under random backpressure, back to back
    rand_en = 1'b1;
    for (int b = 0; b < 100; b++) begin
      dens   = int'($urandom_range(1, 40));
      blk[0] = int'($urandom_range(0, 2047)) - 1024;
      for (int i = 1; i < 64; i++) begin
        if ($urandom_range(1, dens) == 1) begin
          do v = int'($urandom_range(0, 2047)) - 1024; while (v == 0);
          blk[i] = v;
        end else begin
          blk[i] = 0;
        end
      end
      model_block();
      send_block();
    end
    rand_en = 1'b0;
    rdy_fix = 1'b1;
    wait_drain();
    dcheck("last_count", last_seen, 105);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
